// File: rtl/axis_multi_ch_packer.sv
// axis_multi_ch_packer: round-robin multi-channel word packer onto an AXI-Stream.
// Each granted channel word is framed as {data, header} and streamed as BEATS
// beats, LSB first. Optional macro AXIS_PKT_CHID_EN widens the header to
// {chid[7:0], seq[7:0]}; the default build carries seq[7:0] only.
module axis_multi_ch_packer #(
  parameter int DATA_WIDTH      = 4064,
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int NUM_CH          = 2
) (
  input  logic                            m_axis_c2h_aclk,
  input  logic                            m_axis_c2h_aresetn,
  input  logic [NUM_CH*DATA_WIDTH-1:0]    ch_data,
  input  logic [NUM_CH-1:0]               ch_valid,
  output logic [NUM_CH-1:0]               ch_ready,
  output logic [AXIS_DATA_WIDTH-1:0]      m_axis_c2h_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]    m_axis_c2h_tkeep,
  output logic                            m_axis_c2h_tlast,
  output logic                            m_axis_c2h_tvalid,
  input  logic                            m_axis_c2h_tready,
  output logic [1:0]                      sstate
);

`ifdef AXIS_PKT_CHID_EN
  localparam int HDR_W = 16;
`else
  localparam int HDR_W = 8;
`endif
  localparam int PKT_W     = DATA_WIDTH + HDR_W;
  localparam int BEATS     = (PKT_W + AXIS_DATA_WIDTH - 1) / AXIS_DATA_WIDTH;
  localparam int PAD_W     = BEATS * AXIS_DATA_WIDTH;
  localparam int KW        = AXIS_DATA_WIDTH / 8;
  localparam int REM_BYTES = (PKT_W - (BEATS - 1) * AXIS_DATA_WIDTH + 7) / 8;
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [KW-1:0] KEEP_LAST = {KW{1'b1}} >> (KW - REM_BYTES);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;

  state_t                   state_q, state_d;
  logic [PAD_W-1:0]         pkt_q, pkt_d;
  logic [BEAT_W-1:0]        beat_q;
  logic [7:0]               seq_q;
  logic [CH_W-1:0]          ptr_q, gnt;
  logic                     pick_vld, take, last_beat;
  logic [HDR_W-1:0]         hdr;
  logic [DATA_WIDTH-1:0]    ch_word [NUM_CH];

  // First valid channel at or after p, wrapping; returns {found, index}.
  function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] v,
                                            input logic [CH_W-1:0]   p);
    logic [NUM_CH-1:0] rot;
    int                k;
    rot     = NUM_CH'({v, v} >> p);
    rr_pick = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        k = int'(p) + i;
        if (k >= NUM_CH) k = k - NUM_CH;
        rr_pick = {1'b1, CH_W'(k)};
      end
    end
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_word
      assign ch_word[gi] = ch_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign {pick_vld, gnt} = rr_pick(ch_valid, ptr_q);
  assign last_beat       = (beat_q == BEAT_W'(BEATS - 1));
  assign take            = (state_q == IDLE) && pick_vld;

`ifdef AXIS_PKT_CHID_EN
  assign hdr = {8'(gnt), seq_q};
`else
  assign hdr = seq_q;
`endif

  // Frame the granted word, zero-padded up to a whole number of beats.
  always_comb begin
    pkt_d            = '0;
    pkt_d[PKT_W-1:0] = {ch_word[gnt], hdr};
  end

  // State register.
  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) state_q <= IDLE;
    else                     state_q <= state_d;
  end

  // Next state and grant; ready is held off while reset is asserted.
  always_comb begin
    state_d  = state_q;
    ch_ready = '0;
    case (state_q)
      IDLE: if (pick_vld && m_axis_c2h_aresetn) begin
        ch_ready = NUM_CH'(1) << gnt;
        state_d  = SEND;
      end
      SEND: if (m_axis_c2h_tready && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Packet buffer shifts down one beat per accepted non-last beat.
  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      pkt_q  <= '0;
      beat_q <= '0;
      seq_q  <= '0;
      ptr_q  <= '0;
    end else if (take) begin
      pkt_q  <= pkt_d;
      beat_q <= '0;
      ptr_q  <= (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + CH_W'(1);
    end else if (state_q == SEND && m_axis_c2h_tready) begin
      if (last_beat) begin
        beat_q <= '0;
        seq_q  <= seq_q + 8'd1;
      end else begin
        pkt_q  <= pkt_q >> AXIS_DATA_WIDTH;
        beat_q <= beat_q + BEAT_W'(1);
      end
    end
  end

  assign m_axis_c2h_tvalid = (state_q == SEND);
  assign m_axis_c2h_tdata  = pkt_q[AXIS_DATA_WIDTH-1:0];
  assign m_axis_c2h_tlast  = (state_q == SEND) && last_beat;
  assign m_axis_c2h_tkeep  = (state_q != SEND) ? '0 :
                             (last_beat ? KEEP_LAST : {KW{1'b1}});
  assign sstate            = state_q;

endmodule
